dyno_sprite_blitter: RTL
========================

Name: dyno_sprite_blitter

Overview:
- Copies one 32x32 dyno sprite from the sprite ROMs into the frame buffer at a requested screen position.
- Sits directly downstream of the sprite ROMs, which supply two animation frames as whole-sprite arrays.
- Upstream of the frame-buffer write port, and is driven by the game controller.
- Scans pixels row-major, drops transparent and off-screen pixels, and emits one write per visible pixel over a valid/ready handshake.

Parameters:
- SPR_SIZE, 32, sprite width and height in pixels (square).
- X_W, 10, screen x coordinate width.
- Y_W, 9, screen y coordinate width.
- SCREEN_W, 640, visible columns; pixels at x >= SCREEN_W are clipped.
- SCREEN_H, 480, visible rows; pixels at y >= SCREEN_H are clipped.
- TRANSPARENT, 24'd0, colour treated as "do not draw".

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sprite0  in  [31:0][23:0] x [0:31]  frame 0 ROM contents.
- sprite1  in  [31:0][23:0] x [0:31]  frame 1 ROM contents.
- start  in  1  request a blit; sampled only in IDLE.
- frame_sel  in  1  0 selects sprite0, 1 selects sprite1; latched on start.
- pos_x  in  X_W  screen x of the sprite's top-left pixel; latched on start.
- pos_y  in  Y_W  screen y of the sprite's top-left pixel; latched on start.
- wr_valid  out  1  frame-buffer write request.
- wr_ready  in  1  frame buffer accepts the write.
- wr_x  out  X_W  write column.
- wr_y  out  Y_W  write row.
- wr_color  out  24  write data {r,g,b}.
- busy  out  1  blit in progress.
- done  out  1  one-cycle pulse at blit completion.

Behaviour:
- Pixel addressing:
  - Row r (0 = top) is sprite[r].
  - Within a row, packed element index p maps to screen column c = 31 - p, so the leftmost element of each row literal is column 0.
- Reset values: all outputs are 0. The FSM goes to IDLE, and the row/col counters and latched position/frame are cleared. Reset acts immediately in any state; wr_valid drops without completing the transaction.
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - When start=1, latch pos_x, pos_y and frame_sel, clear row/col, set busy=1 and go to FETCH.
  - When start=0, stay in IDLE.
- FETCH: evaluate the pixel at (row, col) of the latched frame.
  - Screen coordinates are sx = pos_x + col and sy = pos_y + row. Sums are computed one bit wider than X_W/Y_W, with no wrap-around.
  - Visible means colour != TRANSPARENT, sx < SCREEN_W and sy < SCREEN_H.
  - If visible: register wr_x=sx, wr_y=sy, wr_color=colour, set wr_valid=1 and go to WRITE.
  - If not visible: advance the counters. If this was the last pixel (row=31, col=31), go to DONE; otherwise stay in FETCH.
  - Each FETCH evaluation costs exactly one cycle.
- WRITE:
  - Hold wr_x, wr_y, wr_color and wr_valid stable while wr_ready=0.
  - On a cycle with wr_valid & wr_ready, clear wr_valid and advance the counters. Go to DONE if the pixel was last, else to FETCH.
  - wr_ready while wr_valid=0 has no effect.
- Counter advance: col increments. When col wraps 31→0, row increments.
- DONE: busy=0 and done=1 for exactly one cycle, then return to IDLE. start is ignored in DONE, so a new request must be held or re-issued in IDLE.
- start while busy is ignored. Inputs pos_x, pos_y and frame_sel may change freely during a blit; only the latched copies are used.
- Sprite array inputs are sampled live during FETCH. They must be stable for the whole blit, which the ROMs guarantee.
- Timing:
  - With wr_ready tied high, each visible pixel costs 2 cycles (FETCH+WRITE) and each invisible pixel costs 1 cycle.
  - Total cycles from start accepted to done pulse = 1024 + V + 1, where V = number of visible pixels.
- Write ordering is strictly row-major: row 0 col 0 first, row 31 col 31 last. At most one write is outstanding.

Test Plan:
- Blank sprite: sprite0 all 0, pos (100,50), frame_sel=0, wr_ready=1 → no wr_valid ever. busy high 1024 cycles, then done pulses on cycle 1025 after the start edge.
- Solid sprite: sprite1 all 24'hFFFFFF, frame_sel=1, pos (0,0), wr_ready=1 → 1024 writes, colour FFFFFF. First write at (0,0), second at (1,0), last at (31,31). done arrives 2049 cycles after start.
- Single pixel: sprite0[3] element p=14 = 24'd16711680, rest 0, pos (200,100) → exactly one write, at wr_x=217, wr_y=103, colour FF0000.
- Clipping: solid sprite0 at pos (620,470) → exactly 20×10=200 writes. All have wr_x in 620..639 and wr_y in 470..479.
- Backpressure and ignored start: single-pixel case with wr_ready low for 5 cycles after wr_valid rises → wr_x, wr_y, wr_color and wr_valid stay stable for 5 cycles, and the write is accepted on the first cycle wr_ready=1. A second start pulse issued during busy produces no additional blit.
- Reset mid-blit: assert reset while in WRITE with wr_valid=1 → wr_valid, busy and done go 0 immediately, with no clock edge needed. After release, a new start blits from row 0, col 0.

Source files
------------

// File: rtl/dyno_sprite_blitter_if.sv
// Frame-buffer write port: one pixel write per valid/ready handshake.
interface dyno_sprite_blitter_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           wr_valid;
  logic           wr_ready;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  logic [23:0]    wr_color;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_color, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_color, output wr_ready);
endinterface

// File: rtl/dyno_sprite_blitter.sv
// Scans a 32x32 sprite row-major and issues one frame-buffer write per
// visible (non-transparent, on-screen) pixel.
module dyno_sprite_blitter #(
  parameter int          SPR_SIZE    = 32,
  parameter int          X_W         = 10,
  parameter int          Y_W         = 9,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter logic [23:0] TRANSPARENT = 24'd0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SPR_SIZE-1:0][23:0]     sprite0 [0:SPR_SIZE-1],
  input  logic [SPR_SIZE-1:0][23:0]     sprite1 [0:SPR_SIZE-1],
  input  logic                          start,
  input  logic                          frame_sel,
  input  logic [X_W-1:0]                pos_x,
  input  logic [Y_W-1:0]                pos_y,
  dyno_sprite_blitter_if.master         wr,
  output logic                          busy,
  output logic                          done
);

  localparam int            CW   = $clog2(SPR_SIZE);
  localparam logic [CW-1:0] LAST = CW'(SPR_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    row;
  logic [CW-1:0]    col;
  logic             frame;
  logic [X_W-1:0]   base_x;
  logic [Y_W-1:0]   base_y;

  logic [23:0]      color;
  logic [X_W:0]     sx;
  logic [Y_W:0]     sy;
  logic             visible;
  logic             last;
  logic [2*CW-1:0]  pix_next;

  // Packed element p holds screen column SPR_SIZE-1-p, so flip the column index.
  assign color    = frame ? sprite1[row][LAST - col] : sprite0[row][LAST - col];
  assign sx       = {1'b0, base_x} + (X_W+1)'(col);
  assign sy       = {1'b0, base_y} + (Y_W+1)'(row);
  assign visible  = (color != TRANSPARENT) &&
                    (sx < (X_W+1)'(SCREEN_W)) &&
                    (sy < (Y_W+1)'(SCREEN_H));
  assign last     = (row == LAST) && (col == LAST);
  assign pix_next = {row, col} + (2*CW)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      frame       <= 1'b0;
      base_x      <= '0;
      base_y      <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_x     <= '0;
      wr.wr_y     <= '0;
      wr.wr_color <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_x <= pos_x;
            base_y <= pos_y;
            frame  <= frame_sel;
            row    <= '0;
            col    <= '0;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (visible) begin
            wr.wr_x     <= sx[X_W-1:0];
            wr.wr_y     <= sy[Y_W-1:0];
            wr.wr_color <= color;
            wr.wr_valid <= 1'b1;
            state       <= WRITE;
          end else begin
            {row, col} <= pix_next;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        WRITE: begin
          if (wr.wr_ready) begin
            wr.wr_valid <= 1'b0;
            {row, col}  <= pix_next;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
